// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied at writeback.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StZdiv} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand decode at latch time.
  logic             is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_div    = op[1];
    is_signed = op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One iteration. p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_hi;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};
    div_hi    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_trial = div_hi - {1'b0, m_q};
    // Restoring step: keep the shifted remainder when the trial subtraction borrows.
    if (div_trial[WIDTH]) begin
      div_next = {div_hi[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end
    step = div_q ? div_next : mul_next;
  end

  // Sign-corrected writeback values, taken from the final iteration.
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    mul_res = neg_q ? -step : step;
    quot    = step[WIDTH-1:0];
    rem     = step[2*WIDTH-1:WIDTH];
    if (div_q) begin
      res_lo = neg_q ? -quot : quot;
      res_hi = rneg_q ? -rem : rem;
    end else begin
      res_lo = mul_res[WIDTH-1:0];
      res_hi = mul_res[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    m_d     = m_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_d  = is_div;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (is_div && (b == '0)) begin
            state_d = StZdiv;
            p_d     = {{WIDTH{1'b0}}, a};
          end else begin
            state_d = StCalc;
            m_d     = is_div ? b_mag : a_mag;
            p_d     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StCalc: begin
        p_d   = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      StZdiv: begin
        state_d = StIdle;
        hi_d    = p_q[WIDTH-1:0];
        lo_d    = {WIDTH{1'b1}};
        done_d  = 1'b1;
        dbz_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed vectors checked with immediate assertions.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_tests  = 0;
  int n_failed = 0;

  int lat, seen;
  bit busy_err, hilo_err;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one rising edge; returns at the negedge after that edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges after the start edge until done; optionally inject start+writes at cycle inject_at.
  task automatic wait_done(input int inject_at, output int latency, output bit b_err,
                           output bit h_err);
    logic [W-1:0] hi0, lo0;
    hi0     = hi;
    lo0     = lo;
    latency = 0;
    b_err   = 1'b0;
    h_err   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inject_at) begin
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd0;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000AAAA;
      end else if (k == inject_at + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        latency = k;
        break;
      end
      if (!busy) b_err = 1'b1;
      if (hi !== hi0 || lo !== lo0) h_err = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    // MULTU max * max
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat, busy_err, hilo_err);
    check("multu_latency", lat, 32);
    check("multu_busy_held", busy_err, 0);
    check("multu_no_partial", hilo_err, 0);
    check("multu_busy_at_done", busy, 0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_dbz", div_by_zero, 0);
    @(negedge clk);
    check("multu_done_pulse", done, 0);

    // MULT -3 * 7
    issue(2'b01, 32'hFFFFFFFD, 32'd7);
    wait_done(0, lat, busy_err, hilo_err);
    check("mult_latency", lat, 32);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);

    // DIVU 100 / 7
    issue(2'b10, 32'd100, 32'd7);
    wait_done(0, lat, busy_err, hilo_err);
    check("divu_latency", lat, 32);
    check("divu_lo", lo, 32'h0000000E);
    check("divu_hi", hi, 32'h00000002);

    // DIV -7 / 2 truncates toward zero
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done(0, lat, busy_err, hilo_err);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);

    // DIV most-negative / -1 wraps
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat, busy_err, hilo_err);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);
    check("div_ovf_dbz", div_by_zero, 0);

    // DIVU by zero: one busy cycle
    issue(2'b10, 32'h00001234, 32'd0);
    check("zdiv_busy", busy, 1);
    check("zdiv_done_early", done, 0);
    wait_done(0, lat, busy_err, hilo_err);
    check("zdiv_latency", lat, 1);
    check("zdiv_dbz", div_by_zero, 1);
    check("zdiv_hi", hi, 32'h00001234);
    check("zdiv_lo", lo, 32'hFFFFFFFF);
    check("zdiv_busy_after", busy, 0);
    @(negedge clk);
    check("zdiv_done_clear", done, 0);
    check("zdiv_dbz_clear", div_by_zero, 0);

    // MULTU with start and HI/LO writes attempted mid-operation
    issue(2'b00, 32'h12345678, 32'h00000010);
    wait_done(5, lat, busy_err, hilo_err);
    check("busy_ign_latency", lat, 32);
    check("busy_ign_no_partial", hilo_err, 0);
    check("busy_ign_hi", hi, 32'h00000001);
    check("busy_ign_lo", lo, 32'h23456780);
    check("busy_ign_dbz", div_by_zero, 0);
    @(negedge clk);
    check("busy_ign_no_restart", busy, 0);

    // Direct writes while idle
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_both_hi", hi, 32'h00000055);
    check("mtlo_both_lo", lo, 32'h00000055);
    hi_we = 1'b1; wdata = 32'h00000066;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_only_hi", hi, 32'h00000066);
    check("mthi_only_lo", lo, 32'h00000055);

    // Start has priority over a simultaneous write
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00000077;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("start_prio_hi", hi, 32'h00000066);
    wait_done(0, lat, busy_err, hilo_err);
    check("start_prio_lo", lo, 32'd6);

    // Set known nonzero HI/LO, then abort a DIV with reset at cycle 10
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00000099;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'b11, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);

    // Fresh MULTU after abort
    issue(2'b00, 32'd6, 32'd7);
    wait_done(0, lat, busy_err, hilo_err);
    check("post_rst_latency", lat, 32);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, WIDTH-parametrised, with architectural HI/LO result registers.
- Sits beside the combinational ALU and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Start/busy/done handshake lets the control unit stall while an operation runs.
- Supports MTHI/MTLO-style direct writes into HI and LO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be at least 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; the unit is reset on a rising clk edge when reset==0
- start  input  1  request a new operation; sampled only when busy==0
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- a  input  WIDTH  multiplicand or dividend; sampled with start
- b  input  WIDTH  multiplier or divisor; sampled with start
- hi_we  input  1  write wdata into HI
- lo_we  input  1  write wdata into LO
- wdata  input  WIDTH  data for hi_we/lo_we
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  output  1  valid with done; set when a divide had b==0
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0.
  - Reset has priority over everything, including mid-operation: the operation is aborted and no done is produced.
- States:
  - IDLE: start==1 at edge N latches a, b and op, goes to CALC and sets busy=1. For a divide with b==0 it goes to ZDIV instead.
  - CALC: one radix-2 iteration per cycle; counter runs 0..WIDTH-1. On the edge that completes iteration WIDTH-1, the sign-corrected result is written to HI/LO, done=1, busy=0, state=IDLE. Done is therefore visible in the cycle after edge N+WIDTH.
  - ZDIV: on edge N+1, hi=a, lo=all ones, div_by_zero=1, done=1, busy=0, state=IDLE.
- done and div_by_zero are single-cycle pulses; both return to 0 on the next edge unless a new completion occurs.
- Multiply: full 2*WIDTH-bit product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- Signed multiply (MULT): operands are converted to magnitudes at latch time, and the 2*WIDTH product is negated at writeback when sign(a) xor sign(b).
- Divide: restoring, unsigned on magnitudes; lo=quotient, hi=remainder.
  - DIV quotient sign = sign(a) xor sign(b); remainder sign = sign(a) (truncation toward zero).
  - DIV of the most-negative value by -1 gives lo=most-negative, hi=0, with no flag. This falls out of modulo-2^WIDTH arithmetic.
- start while busy==1 is ignored; operands and op are not re-sampled.
- hi_we/lo_we:
  - Honoured only when busy==0 and start==0; the write takes effect at that edge.
  - Ignored while busy, and ignored in a cycle where start is accepted (start has priority).
  - hi_we and lo_we may be asserted together.
- HI/LO hold their value between completions and writes. Results appear only with done, never partially during CALC.
- Sign-extension and negation are performed at WIDTH (operands) or 2*WIDTH (product). No overflow flag exists.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 32 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0; busy high for those 32 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done and div_by_zero both 1 in the cycle after the start edge; hi=0x1234, lo=0xFFFFFFFF; busy high for one cycle; both pulses clear on the next edge.
- During a MULTU, assert start with new operands and hi_we=1, wdata=0xAAAA at cycle 5 -> both ignored, original result delivered. Afterwards hi_we=1, lo_we=1, wdata=0x55 while idle -> hi=lo=0x55 after one edge.
- Drive reset=0 for one edge at cycle 10 of a DIV -> busy=0, hi=lo=0, done never pulses. A fresh MULTU 6*7 afterwards -> lo=42, hi=0 after 32 cycles.
